ddr_job_scheduler: RTL and testbench

- Shares the single-burst DDR controller between two job streams:
  - a host write job that streams 512-bit words into DDR;
  - a config read job that pulls bursts out toward the configuration buffer.
- Keeps shadow write and read pointers and re-issues the controller's address load whenever the transfer direction changes, because a load overwrites both controller pointers.
- Interleaves the two jobs round-robin at burst granularity.

---
 rtl/ddr_sched_pkg.sv | 27 ++
 rtl/ddr_rr_arb2.sv | 39 +++
 rtl/ddr_job_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_ddr_job_scheduler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR job scheduler.
//   sched_state_t : scheduler FSM state encoding
//   dir_t         : transfer direction last programmed into the controller
//   BURST_INC_DEF : default address step per 512-bit burst
//   DATA_W        : DDR data word width
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOAD,
    ST_ISSUE_WR,
    ST_WAIT_WR,
    ST_ISSUE_RD,
    ST_WAIT_RD
  } sched_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_WR,
    DIR_RD
  } dir_t;

  localparam int unsigned BURST_INC_DEF = 64;
  localparam int unsigned DATA_W        = 512;

endpackage

// File: rtl/ddr_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
//   clk, rst        : clock, synchronous active-high reset
//   req_wr, req_rd  : eligibility of the write / read job
//   accept          : the scheduler commits the grant this cycle
//   gnt_wr, gnt_rd  : one-hot (or zero) grant, combinational
// Reset leaves last-grant = READ so the write side wins the first tie.
module ddr_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic accept,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_rd;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (req_wr && req_rd) begin
      gnt_wr = last_rd;
      gnt_rd = !last_rd;
    end else begin
      gnt_wr = req_wr;
      gnt_rd = req_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd <= 1'b1;
    end else if (accept && (gnt_wr || gnt_rd)) begin
      last_rd <= gnt_rd;
    end
  end

endmodule

// File: rtl/ddr_job_scheduler.sv
// Shares a single-burst DDR controller between a host write job and a
// config read job, interleaving them round-robin one burst at a time.
// Shadow write/read pointers are kept here; since a controller address
// load overwrites both of its pointers, a load is re-issued whenever the
// transfer direction changes.
//   clk, rst                 : clock, synchronous active-high reset
//   i_wr_* / o_wr_*          : write job start, host word stream, status
//   i_rd_* / o_rd_*          : read job start, status
//   i_config_buff_full       : stalls the read job only
//   o_load, o_strt_addr      : controller address load
//   o_ddr_wr, o_ddr_data     : controller write request and data
//   i_ddr_wr_done            : controller write-done pulse
//   o_ddr_rd                 : controller read request (held until first beat)
//   i_ddr_rd_data_valid      : controller read beat
//   i_ddr_rd_done            : controller read-done pulse
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | after reset; arbitrates exactly like ARB
// ARB      | pick a job; capture host word on a write grant
// LOAD     | o_load with the granted shadow pointer
// ISSUE_WR | o_ddr_wr high for this one cycle
// WAIT_WR  | wait for i_ddr_wr_done, advance write pointer/count
// ISSUE_RD | o_ddr_rd high (held into WAIT_RD)
// WAIT_RD  | drop o_ddr_rd on first beat; wait for i_ddr_rd_done
module ddr_job_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int LEN_W     = 16,
  parameter int BURST_INC = BURST_INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_start,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_wr_busy,
  output logic              o_wr_done,
  input  logic              i_rd_start,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [LEN_W-1:0]  i_rd_len,
  output logic              o_rd_busy,
  output logic              o_rd_done,
  input  logic              i_config_buff_full,
  output logic              o_load,
  output logic [ADDR_W-1:0] o_strt_addr,
  output logic [DATA_W-1:0] o_ddr_data,
  output logic              o_ddr_wr,
  input  logic              i_ddr_wr_done,
  output logic              o_ddr_rd,
  input  logic              i_ddr_rd_data_valid,
  input  logic              i_ddr_rd_done
);

  localparam logic [ADDR_W-1:0] PTR_INC = ADDR_W'(BURST_INC);
  localparam logic [LEN_W-1:0]  CNT_ONE = LEN_W'(1);

  sched_state_t      state;
  dir_t              cur_dir;
  dir_t              last_dir;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  wr_cnt;
  logic [LEN_W-1:0]  rd_cnt;

  logic wr_elig;
  logic rd_elig;
  logic arb_phase;
  logic gnt_wr;
  logic gnt_rd;

  assign wr_elig   = o_wr_busy && i_wr_valid;
  assign rd_elig   = o_rd_busy && !i_config_buff_full;
  assign arb_phase = (state == ST_IDLE) || (state == ST_ARB);

  ddr_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_wr (wr_elig),
    .req_rd (rd_elig),
    .accept (arb_phase),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_dir     <= DIR_NONE;
      last_dir    <= DIR_NONE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      o_wr_ready  <= 1'b0;
      o_wr_busy   <= 1'b0;
      o_wr_done   <= 1'b0;
      o_rd_busy   <= 1'b0;
      o_rd_done   <= 1'b0;
      o_load      <= 1'b0;
      o_strt_addr <= '0;
      o_ddr_data  <= '0;
      o_ddr_wr    <= 1'b0;
      o_ddr_rd    <= 1'b0;
    end else begin
      o_load     <= 1'b0;
      o_wr_ready <= 1'b0;
      o_wr_done  <= 1'b0;
      o_rd_done  <= 1'b0;
      o_ddr_wr   <= 1'b0;

      // A new job moves its shadow pointer away from wherever the
      // controller was left, so a matching last direction is forgotten
      // to force a fresh load. FSM updates below take precedence.
      if (i_wr_start && !o_wr_busy) begin
        wr_ptr <= i_wr_addr;
        wr_cnt <= i_wr_len;
        if (i_wr_len == '0) o_wr_done <= 1'b1;
        else                o_wr_busy <= 1'b1;
        if (last_dir == DIR_WR) last_dir <= DIR_NONE;
      end
      if (i_rd_start && !o_rd_busy) begin
        rd_ptr <= i_rd_addr;
        rd_cnt <= i_rd_len;
        if (i_rd_len == '0) o_rd_done <= 1'b1;
        else                o_rd_busy <= 1'b1;
        if (last_dir == DIR_RD) last_dir <= DIR_NONE;
      end

      case (state)
        ST_IDLE, ST_ARB: begin
          if (gnt_wr) begin
            o_wr_ready <= 1'b1;
            o_ddr_data <= i_wr_data;
            cur_dir    <= DIR_WR;
            if (last_dir != DIR_WR) begin
              state       <= ST_LOAD;
              o_load      <= 1'b1;
              o_strt_addr <= wr_ptr;
            end else begin
              state    <= ST_ISSUE_WR;
              o_ddr_wr <= 1'b1;
            end
          end else if (gnt_rd) begin
            cur_dir <= DIR_RD;
            if (last_dir != DIR_RD) begin
              state       <= ST_LOAD;
              o_load      <= 1'b1;
              o_strt_addr <= rd_ptr;
            end else begin
              state    <= ST_ISSUE_RD;
              o_ddr_rd <= 1'b1;
            end
          end else begin
            state <= ST_ARB;
          end
        end

        ST_LOAD: begin
          last_dir <= cur_dir;
          if (cur_dir == DIR_WR) begin
            state    <= ST_ISSUE_WR;
            o_ddr_wr <= 1'b1;
          end else begin
            state    <= ST_ISSUE_RD;
            o_ddr_rd <= 1'b1;
          end
        end

        ST_ISSUE_WR: state <= ST_WAIT_WR;

        ST_WAIT_WR: begin
          if (i_ddr_wr_done) begin
            wr_ptr <= wr_ptr + PTR_INC;
            wr_cnt <= wr_cnt - CNT_ONE;
            if (wr_cnt == CNT_ONE) begin
              o_wr_busy <= 1'b0;
              o_wr_done <= 1'b1;
            end
            state <= ST_ARB;
          end
        end

        ST_ISSUE_RD: state <= ST_WAIT_RD;

        ST_WAIT_RD: begin
          // Once a beat arrives the controller is out of idle, so the
          // request can be released without risk of a second burst.
          if (i_ddr_rd_data_valid) o_ddr_rd <= 1'b0;
          if (i_ddr_rd_done) begin
            o_ddr_rd <= 1'b0;
            rd_ptr   <= rd_ptr + PTR_INC;
            rd_cnt   <= rd_cnt - CNT_ONE;
            if (rd_cnt == CNT_ONE) begin
              o_rd_busy <= 1'b0;
              o_rd_done <= 1'b1;
            end
            state <= ST_ARB;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_job_scheduler.sv
// Bench for ddr_job_scheduler: directed scenarios plus randomized job
// rounds. A behavioural DDR controller checks every burst address and
// data word against per-job expectations derived from start address,
// length and the host word stream.
module tb_ddr_job_scheduler;

  localparam int ADDR_W = 27;
  localparam int LEN_W  = 16;
  localparam int INC    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_wr_start;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [LEN_W-1:0]  i_wr_len;
  logic              i_wr_valid;
  logic [511:0]      i_wr_data;
  logic              o_wr_ready, o_wr_busy, o_wr_done;
  logic              i_rd_start;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [LEN_W-1:0]  i_rd_len;
  logic              o_rd_busy, o_rd_done;
  logic              i_config_buff_full;
  logic              o_load;
  logic [ADDR_W-1:0] o_strt_addr;
  logic [511:0]      o_ddr_data;
  logic              o_ddr_wr;
  logic              i_ddr_wr_done;
  logic              o_ddr_rd;
  logic              i_ddr_rd_data_valid;
  logic              i_ddr_rd_done;

  always #5 clk = ~clk;

  ddr_job_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_wr_start          (i_wr_start),
    .i_wr_addr           (i_wr_addr),
    .i_wr_len            (i_wr_len),
    .i_wr_valid          (i_wr_valid),
    .i_wr_data           (i_wr_data),
    .o_wr_ready          (o_wr_ready),
    .o_wr_busy           (o_wr_busy),
    .o_wr_done           (o_wr_done),
    .i_rd_start          (i_rd_start),
    .i_rd_addr           (i_rd_addr),
    .i_rd_len            (i_rd_len),
    .o_rd_busy           (o_rd_busy),
    .o_rd_done           (o_rd_done),
    .i_config_buff_full  (i_config_buff_full),
    .o_load              (o_load),
    .o_strt_addr         (o_strt_addr),
    .o_ddr_data          (o_ddr_data),
    .o_ddr_wr            (o_ddr_wr),
    .i_ddr_wr_done       (i_ddr_wr_done),
    .o_ddr_rd            (o_ddr_rd),
    .i_ddr_rd_data_valid (i_ddr_rd_data_valid),
    .i_ddr_rd_done       (i_ddr_rd_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expectations and logs
  logic [511:0]      host_q[$];
  logic [ADDR_W-1:0] exp_wr_addr[$];
  logic [511:0]      exp_wr_data[$];
  logic [ADDR_W-1:0] exp_rd_addr[$];
  logic [ADDR_W-1:0] load_log[$];
  int                req_log[$];   // 0 = write burst, 1 = read burst
  int                wr_done_cnt = 0, rd_done_cnt = 0;
  int                wr_jobs_exp = 0, rd_jobs_exp = 0;
  int                full_mode = 0;  // 0 empty, 1 full, 2 random

  function automatic int count_rd_reqs();
    int n = 0;
    foreach (req_log[i]) if (req_log[i] == 1) n++;
    return n;
  endfunction

  // Host word source: presents the head word, pops it when accepted.
  always @(negedge clk) begin
    if (o_wr_ready && host_q.size() > 0) void'(host_q.pop_front());
    i_wr_valid = (host_q.size() > 0);
    i_wr_data  = (host_q.size() > 0) ? host_q[0] : '0;
  end

  always @(negedge clk) begin
    case (full_mode)
      1:       i_config_buff_full = 1'b1;
      2:       i_config_buff_full = ($urandom_range(0, 2) == 0);
      default: i_config_buff_full = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_done) wr_done_cnt++;
      if (o_rd_done) rd_done_cnt++;
    end
  end

  // Behavioural single-burst DDR controller. A load sets both pointers.
  localparam int C_IDLE = 0, C_WR = 1, C_RD_LAT = 2, C_RD_BEAT = 3, C_RD_DONE = 4, C_WAIT = 5;
  int                c_st = C_IDLE;
  int                c_cnt;
  logic [ADDR_W-1:0] c_wr_ptr = '0, c_rd_ptr = '0;
  logic [511:0]      c_data;
  bit                extra_wr;
  bit                pend_wr, pend_wr_last, pend_rd, pend_rd_last;

  always @(negedge clk) begin
    i_ddr_wr_done       = 1'b0;
    i_ddr_rd_done       = 1'b0;
    i_ddr_rd_data_valid = 1'b0;
    if (rst) begin
      c_st    = C_IDLE;
      pend_wr = 1'b0;
      pend_rd = 1'b0;
    end else begin
      if (pend_wr) begin
        chk("wr_done_timing", o_wr_done, pend_wr_last);
        pend_wr = 1'b0;
      end
      if (pend_rd) begin
        chk("rd_done_timing", o_rd_done, pend_rd_last);
        pend_rd = 1'b0;
      end
      if (o_load) begin
        chk("load_excl_req", {o_ddr_wr, o_ddr_rd}, 0);
        chk("load_ctrl_idle", c_st == C_IDLE, 1);
        c_wr_ptr = o_strt_addr;
        c_rd_ptr = o_strt_addr;
        load_log.push_back(o_strt_addr);
      end
      case (c_st)
        C_IDLE: begin
          if (o_ddr_wr) begin
            c_data   = o_ddr_data;
            c_cnt    = $urandom_range(1, 3);
            extra_wr = 1'b0;
            c_st     = C_WR;
            req_log.push_back(0);
          end else if (o_ddr_rd) begin
            c_cnt = $urandom_range(1, 3);
            c_st  = C_RD_LAT;
            req_log.push_back(1);
          end
        end
        C_WR: begin
          if (o_ddr_wr) extra_wr = 1'b1;
          c_cnt--;
          if (c_cnt == 0) begin
            i_ddr_wr_done = 1'b1;
            chk("wr_req_single", extra_wr, 0);
            chk512("wr_data_stable", o_ddr_data, c_data);
            chk("wr_burst_expected", exp_wr_addr.size() != 0, 1);
            if (exp_wr_addr.size() != 0) begin
              chk("wr_addr", c_wr_ptr, exp_wr_addr.pop_front());
              chk512("wr_data", c_data, exp_wr_data.pop_front());
            end
            c_wr_ptr     = c_wr_ptr + ADDR_W'(INC);
            pend_wr      = 1'b1;
            pend_wr_last = (exp_wr_addr.size() == 0);
            c_st         = C_WAIT;
          end
        end
        C_RD_LAT: begin
          c_cnt--;
          if (c_cnt == 0) begin
            i_ddr_rd_data_valid = 1'b1;
            chk("rd_req_held", o_ddr_rd, 1);
            c_st = C_RD_BEAT;
          end
        end
        C_RD_BEAT: begin
          i_ddr_rd_data_valid = 1'b1;
          chk("rd_req_dropped", o_ddr_rd, 0);
          c_st = C_RD_DONE;
        end
        C_RD_DONE: begin
          i_ddr_rd_done = 1'b1;
          chk("rd_burst_expected", exp_rd_addr.size() != 0, 1);
          if (exp_rd_addr.size() != 0) chk("rd_addr", c_rd_ptr, exp_rd_addr.pop_front());
          c_rd_ptr     = c_rd_ptr + ADDR_W'(INC);
          pend_rd      = 1'b1;
          pend_rd_last = (exp_rd_addr.size() == 0);
          c_st         = C_WAIT;
        end
        default: c_st = C_IDLE;
      endcase
    end
  end

  task automatic clear_model();
    host_q.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_rd_addr.delete();
    load_log.delete();
    req_log.delete();
    wr_done_cnt = 0;
    rd_done_cnt = 0;
    wr_jobs_exp = 0;
    rd_jobs_exp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Called at a negedge; starts the selected jobs together.
  task automatic start_jobs(input bit dw, input logic [ADDR_W-1:0] wa, input int wl,
                            input bit dr, input logic [ADDR_W-1:0] ra, input int rl);
    logic [511:0] w;
    i_wr_start = dw;
    i_wr_addr  = wa;
    i_wr_len   = LEN_W'(wl);
    i_rd_start = dr;
    i_rd_addr  = ra;
    i_rd_len   = LEN_W'(rl);
    if (dw) begin
      wr_jobs_exp++;
      for (int k = 0; k < wl; k++) begin
        w = rand512();
        host_q.push_back(w);
        exp_wr_data.push_back(w);
        exp_wr_addr.push_back(ADDR_W'(64'(wa) + 64'(k * INC)));
      end
    end
    if (dr) begin
      rd_jobs_exp++;
      for (int k = 0; k < rl; k++) exp_rd_addr.push_back(ADDR_W'(64'(ra) + 64'(k * INC)));
    end
    @(negedge clk);
    i_wr_start = 1'b0;
    i_rd_start = 1'b0;
    if (dw) begin
      chk("wr_busy_after_start", o_wr_busy, wl != 0);
      if (wl == 0) chk("wr_len0_done", o_wr_done, 1);
    end
    if (dr) begin
      chk("rd_busy_after_start", o_rd_busy, rl != 0);
      if (rl == 0) chk("rd_len0_done", o_rd_done, 1);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((wr_done_cnt != wr_jobs_exp || rd_done_cnt != rd_jobs_exp ||
            exp_wr_addr.size() != 0 || exp_rd_addr.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_wr_done_cnt"}, wr_done_cnt, wr_jobs_exp);
    chk({tag, "_rd_done_cnt"}, rd_done_cnt, rd_jobs_exp);
    chk({tag, "_bursts_left"}, exp_wr_addr.size() + exp_rd_addr.size(), 0);
    chk({tag, "_busy_clear"}, {o_wr_busy, o_rd_busy}, 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_ld[4];
    int                exp_rq[4];
    int                act_before;
    int                rd_before;
    int                n;
    rst = 1'b1;
    i_wr_start = 1'b0; i_wr_addr = '0; i_wr_len = '0;
    i_rd_start = 1'b0; i_rd_addr = '0; i_rd_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outs", {o_load, o_ddr_wr, o_ddr_rd, o_wr_ready}, 0);
    chk("reset_flags", {o_wr_busy, o_rd_busy, o_wr_done, o_rd_done}, 0);
    chk("reset_strt_addr", o_strt_addr, 0);
    chk512("reset_ddr_data", o_ddr_data, '0);
    rst = 1'b0;
    clear_model();
    @(negedge clk);

    // Single write job: one load, two bursts
    start_jobs(1, 27'h100, 2, 0, '0, 0);
    drain("wr_only");
    chk("wr_only_loads", load_log.size(), 1);
    if (load_log.size() > 0) chk("wr_only_load_addr", load_log[0], 27'h100);
    chk("wr_only_reqs", req_log.size(), 2);
    chk("wr_only_no_rd", count_rd_reqs(), 0);

    // Single read job
    load_log.delete(); req_log.delete();
    start_jobs(0, '0, 0, 1, 27'h2000, 1);
    drain("rd_only");
    chk("rd_only_loads", load_log.size(), 1);
    if (load_log.size() > 0) chk("rd_only_load_addr", load_log[0], 27'h2000);
    chk("rd_only_reqs", count_rd_reqs(), 1);

    // Both always eligible: W,R,W,R with a load before every burst
    do_reset();
    start_jobs(1, 27'h0, 2, 1, 27'h1000, 2);
    drain("rr");
    exp_ld[0] = 27'h0;  exp_ld[1] = 27'h1000; exp_ld[2] = 27'h40; exp_ld[3] = 27'h1040;
    exp_rq[0] = 0; exp_rq[1] = 1; exp_rq[2] = 0; exp_rq[3] = 1;
    chk("rr_load_cnt", load_log.size(), 4);
    chk("rr_req_cnt", req_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < load_log.size()) chk($sformatf("rr_load%0d", i), load_log[i], exp_ld[i]);
      if (i < req_log.size())  chk($sformatf("rr_grant%0d", i), req_log[i], exp_rq[i]);
    end

    // Buffer full stalls only the read job
    load_log.delete(); req_log.delete();
    full_mode = 1;
    @(negedge clk);
    start_jobs(1, 27'h4000, 3, 1, 27'h6000, 1);
    repeat (20) @(negedge clk);
    chk("full_no_rd_req", count_rd_reqs(), 0);
    chk("full_wr_progress", exp_wr_addr.size() < 3, 1);
    full_mode = 0;
    drain("full");
    chk("full_rd_after_release", count_rd_reqs(), 1);

    // Zero-length jobs: done next cycle, no controller activity
    act_before = load_log.size() + req_log.size();
    start_jobs(1, 27'h7000, 0, 1, 27'h7100, 0);
    repeat (5) @(negedge clk);
    chk("len0_no_activity", load_log.size() + req_log.size(), act_before);
    drain("len0");

    // Start while busy is ignored; interleaved reads force reloads that
    // expose the write pointer
    start_jobs(1, 27'h3000, 3, 1, 27'h8000, 2);
    repeat (2) @(negedge clk);
    i_wr_start = 1'b1; i_wr_addr = 27'h5000; i_wr_len = LEN_W'(1);
    @(negedge clk);
    i_wr_start = 1'b0;
    chk("busy_start_ignored", o_wr_busy, 1);
    drain("ignore");

    // Reset while waiting for a write burst
    load_log.delete(); req_log.delete();
    start_jobs(1, 27'h9000, 3, 0, '0, 0);
    n = 0;
    while (!o_ddr_wr && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid_saw_wr", o_ddr_wr, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ctrl_outs", {o_load, o_ddr_wr, o_ddr_rd, o_wr_ready}, 0);
    chk("rst_mid_flags", {o_wr_busy, o_rd_busy, o_wr_done, o_rd_done}, 0);
    chk("rst_mid_strt_addr", o_strt_addr, 0);
    chk512("rst_mid_ddr_data", o_ddr_data, '0);
    rst = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", wr_done_cnt, 0);
    start_jobs(1, 27'hA000, 1, 0, '0, 0);
    drain("post_rst");
    chk("post_rst_loads", load_log.size(), 1);
    if (load_log.size() > 0) chk("post_rst_load_addr", load_log[0], 27'hA000);

    // Pointer wrap at the top of the address space
    start_jobs(1, 27'h7FFFFC0, 2, 1, 27'h7FFFF80, 3);
    drain("wrap");

    // Randomized rounds with a flickering buffer-full
    full_mode = 2;
    for (int r = 0; r < 8; r++) begin
      rd_before = $urandom_range(0, 3);
      start_jobs($urandom_range(0, 3) != 0, ADDR_W'($urandom), $urandom_range(0, 4),
                 $urandom_range(0, 3) != 0, ADDR_W'($urandom), $urandom_range(0, 4));
      repeat (rd_before) @(negedge clk);
      drain($sformatf("rand%0d", r));
    end
    full_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
